// File: rtl/oak_core.sv
// oak_core: two-state (IDLE/EXEC) frame CPU with a 16-entry register file and a small data RAM.
// Define OAK_MUL_EN to turn opcode F into an unsigned multiply; otherwise opcode F is reported as illegal.
module oak_core #(
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 32,
  parameter int PC_W      = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              frame_valid,
  input  logic [16:0]       frame,
  output logic              frame_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [PC_W-1:0]   pc,
  output logic              flag_z,
  output logic              flag_c,
  output logic              illegal
);

  localparam int RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  typedef enum logic {IDLE, EXEC} state_t;

  state_t            state;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [16];
  logic [DATA_W-1:0] ram  [RAM_DEPTH];

  logic [3:0]        op, ra, rb, rd;
  logic [7:0]        imm8;
  logic [3:0]        off4;
  logic [RAM_AW-1:0] addr;
  logic [DATA_W-1:0] a, b, diff;
  logic [DATA_W:0]   sum;
  logic              unused_frame_lsb;

  logic [DATA_W-1:0] result;
  logic              carry, set_flags, reg_we, ram_we, is_illegal;
  logic [3:0]        reg_wa;
  logic [PC_W-1:0]   pc_next;

`ifdef OAK_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
`endif

  // Bit 0 of the frame carries no information.
  assign unused_frame_lsb = frame[0];

  assign frame_ready = (state == IDLE);
  assign op   = ir[15:12];
  assign ra   = ir[11:8];
  assign rb   = ir[7:4];
  assign rd   = ir[3:0];
  assign imm8 = ir[7:0];
  assign off4 = ir[3:0];
  assign addr = imm8[RAM_AW-1:0];
  assign a    = regs[ra];
  assign b    = regs[rb];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  // Decode and execute the latched instruction; consumed only on the EXEC edge.
  always_comb begin
    result     = '0;
    carry      = 1'b0;
    set_flags  = 1'b0;
    reg_we     = 1'b0;
    reg_wa     = rd;
    ram_we     = 1'b0;
    is_illegal = 1'b0;
    pc_next    = pc + PC_W'(1);
    case (op)
      4'h0: result = '0;
      4'h1: result = a;
      4'h2: begin result = DATA_W'(imm8); reg_we = 1'b1; reg_wa = ra; end
      4'h3: begin result = sum[DATA_W-1:0]; carry = sum[DATA_W]; set_flags = 1'b1; reg_we = 1'b1; end
      4'h4: begin result = diff; carry = (a < b); set_flags = 1'b1; reg_we = 1'b1; end
      4'h5: begin result = a & b; set_flags = 1'b1; reg_we = 1'b1; end
      4'h6: begin result = a | b; set_flags = 1'b1; reg_we = 1'b1; end
      4'h7: begin result = b; reg_we = 1'b1; reg_wa = ra; end
      4'h8: begin result = ram[addr]; reg_we = 1'b1; reg_wa = ra; end
      4'h9: begin result = a; ram_we = 1'b1; end
      4'hA: begin result = a ^ b; set_flags = 1'b1; reg_we = 1'b1; end
      4'hB: begin result = diff; carry = (a < b); set_flags = 1'b1; end
      4'hC: begin pc_next = PC_W'(imm8); result = DATA_W'(pc_next); end
      4'hD: begin
        if (a != b) pc_next = pc + PC_W'($signed(off4));
        result = DATA_W'(pc_next);
      end
      4'hE: begin
        if (a == b) pc_next = pc + PC_W'($signed(off4));
        result = DATA_W'(pc_next);
      end
      4'hF: begin
`ifdef OAK_MUL_EN
        result    = prod[DATA_W-1:0];
        carry     = |prod[2*DATA_W-1:DATA_W];
        set_flags = 1'b1;
        reg_we    = 1'b1;
`else
        is_illegal = 1'b1;
`endif
      end
    endcase
  end

  // Control FSM, architectural state and registered outputs; reset aborts any EXEC in flight.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state      <= IDLE;
      ir         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      pc         <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      dout_valid <= 1'b0;
      illegal    <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            ir    <= frame[16:1];
            state <= EXEC;
          end
        end
        EXEC: begin
          dout       <= result;
          dout_valid <= 1'b1;
          illegal    <= is_illegal;
          pc         <= pc_next;
          if (set_flags) begin
            flag_z <= (result == '0);
            flag_c <= carry;
          end
          if (reg_we) regs[reg_wa] <= result;
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge sysclk) begin
    if (!reset && state == EXEC && ram_we) ram[addr] <= a;
  end

endmodule

// File: tb/tb_oak_core.sv
// Testbench for oak_core: directed vector table, multi-cycle corner sequences and a randomized
// run checked against an arithmetic reference model. Honours OAK_MUL_EN like the design.
module tb_oak_core;

  localparam int DATA_W = 8;
  localparam int RAM_DEPTH = 32;
  localparam int PC_W = 8;
  localparam int DMOD = 1 << DATA_W;
  localparam int PCMOD = 1 << PC_W;

  logic              sysclk;
  logic              reset;
  logic              frame_valid;
  logic [16:0]       frame;
  logic              frame_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic [PC_W-1:0]   pc;
  logic              flag_z;
  logic              flag_c;
  logic              illegal;

  int checks = 0;
  int errors = 0;

  int m_regs [16];
  int m_ram [RAM_DEPTH];
  int m_pc;
  bit m_z, m_c, m_ill;
  int m_dout;

  typedef struct {
    string       name;
    logic [16:0] f;
    logic [7:0]  dout;
    logic [7:0]  pc;
    logic        z;
    logic        c;
    logic        ill;
  } vec_t;

  vec_t vecs [$];

  oak_core #(.DATA_W(DATA_W), .RAM_DEPTH(RAM_DEPTH), .PC_W(PC_W)) dut (
    .sysclk(sysclk), .reset(reset), .frame_valid(frame_valid), .frame(frame),
    .frame_ready(frame_ready), .dout(dout), .dout_valid(dout_valid), .pc(pc),
    .flag_z(flag_z), .flag_c(flag_c), .illegal(illegal)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  function automatic logic [16:0] mk(input int op, input int ra, input int rb, input int rd);
    return {op[3:0], ra[3:0], rb[3:0], rd[3:0], 1'b0};
  endfunction

  function automatic logic [16:0] mki(input int op, input int ra, input int imm);
    return {op[3:0], ra[3:0], imm[7:0], 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_pc = 0; m_z = 0; m_c = 0; m_ill = 0; m_dout = 0;
  endtask

  // Reference behaviour from the instruction set rules, using plain integer arithmetic.
  task automatic modelExec(input logic [16:0] f);
    int op, ra, rb, rd, imm, off, a, b, res, npc;
    longint p;
    bit flags, cy;
    op = int'(f[16:13]); ra = int'(f[12:9]); rb = int'(f[8:5]); rd = int'(f[4:1]);
    imm = int'(f[8:1]);
    off = (rd > 7) ? rd - 16 : rd;
    a = m_regs[ra]; b = m_regs[rb];
    res = 0; flags = 0; cy = 0; m_ill = 0;
    npc = (m_pc + 1) % PCMOD;
    case (op)
      0: res = 0;
      1: res = a;
      2: begin res = imm % DMOD; m_regs[ra] = res; end
      3: begin res = (a + b) % DMOD; cy = (a + b) >= DMOD; flags = 1; m_regs[rd] = res; end
      4: begin res = (a - b + DMOD) % DMOD; cy = a < b; flags = 1; m_regs[rd] = res; end
      5: begin res = a & b; flags = 1; m_regs[rd] = res; end
      6: begin res = a | b; flags = 1; m_regs[rd] = res; end
      7: begin res = b; m_regs[ra] = b; end
      8: begin res = m_ram[imm % RAM_DEPTH]; m_regs[ra] = res; end
      9: begin res = a; m_ram[imm % RAM_DEPTH] = a; end
      10: begin res = a ^ b; flags = 1; m_regs[rd] = res; end
      11: begin res = (a - b + DMOD) % DMOD; cy = a < b; flags = 1; end
      12: begin npc = imm % PCMOD; res = npc % DMOD; end
      13: begin if (a != b) npc = ((m_pc + off) % PCMOD + PCMOD) % PCMOD; res = npc % DMOD; end
      14: begin if (a == b) npc = ((m_pc + off) % PCMOD + PCMOD) % PCMOD; res = npc % DMOD; end
      default: begin
`ifdef OAK_MUL_EN
        p = longint'(a) * longint'(b);
        res = int'(p % DMOD); cy = (p / DMOD) != 0; flags = 1; m_regs[rd] = res;
`else
        p = 0;
        m_ill = 1; res = 0;
`endif
      end
    endcase
    if (flags) begin m_z = (res == 0); m_c = cy; end
    m_pc = npc;
    m_dout = res;
  endtask

  task automatic doReset();
    reset = 1'b1; frame_valid = 1'b0; frame = '0;
    repeat (2) @(posedge sysclk);
    #1 reset = 1'b0;
    modelReset();
  endtask

  // One full handshake plus EXEC; returns 1 ns after the EXEC edge.
  task automatic applyStimulus(input logic [16:0] f);
    int waitc = 0;
    while (!frame_ready && waitc < 4) begin @(posedge sysclk); #1; waitc++; end
    if (!frame_ready) checkOutput("ready_timeout", 32'(frame_ready), 1);
    frame = f; frame_valid = 1'b1;
    @(posedge sysclk); #1;
    frame_valid = 1'b0;
    frame = 17'($urandom);
    checkOutput("ready_low_in_exec", 32'(frame_ready), 0);
    modelExec(f);
    @(posedge sysclk); #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_dout"}, 32'(dout), 32'(m_dout));
    checkOutput({tag, "_valid"}, 32'(dout_valid), 1);
    checkOutput({tag, "_pc"}, 32'(pc), 32'(m_pc));
    checkOutput({tag, "_z"}, 32'(flag_z), 32'(m_z));
    checkOutput({tag, "_c"}, 32'(flag_c), 32'(m_c));
    checkOutput({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
  endtask

  initial begin
    reset = 1'b1; frame_valid = 1'b0; frame = '0;
    for (int i = 0; i < RAM_DEPTH; i++) m_ram[i] = 0;
    doReset();

    checkOutput("rst_ready", 32'(frame_ready), 1);
    checkOutput("rst_dout", 32'(dout), 0);
    checkOutput("rst_valid", 32'(dout_valid), 0);
    checkOutput("rst_pc", 32'(pc), 0);
    checkOutput("rst_flags", {30'b0, flag_z, flag_c}, 0);
    checkOutput("rst_illegal", 32'(illegal), 0);

    vecs.push_back('{"ldi_r1",     mki(2, 1, 8'h05),  8'h05, 8'h01, 0, 0, 0});
    vecs.push_back('{"ldi_r2",     mki(2, 2, 8'h03),  8'h03, 8'h02, 0, 0, 0});
    vecs.push_back('{"add_r3",     mk(3, 1, 2, 3),    8'h08, 8'h03, 0, 0, 0});
    vecs.push_back('{"ldi_r1_ff",  mki(2, 1, 8'hFF),  8'hFF, 8'h04, 0, 0, 0});
    vecs.push_back('{"ldi_r2_01",  mki(2, 2, 8'h01),  8'h01, 8'h05, 0, 0, 0});
    vecs.push_back('{"add_wrap",   mk(3, 1, 2, 4),    8'h00, 8'h06, 1, 1, 0});
    vecs.push_back('{"sub_borrow", mk(4, 2, 1, 5),    8'h02, 8'h07, 0, 1, 0});
    vecs.push_back('{"rst_1f",     mki(9, 3, 8'h1F),  8'h08, 8'h08, 0, 1, 0});
    vecs.push_back('{"rld_alias",  mki(8, 6, 8'h3F),  8'h08, 8'h09, 0, 1, 0});
    vecs.push_back('{"ld_r6",      mk(1, 6, 0, 0),    8'h08, 8'h0A, 0, 1, 0});
    vecs.push_back('{"ldi_r1_07",  mki(2, 1, 8'h07),  8'h07, 8'h0B, 0, 1, 0});
    vecs.push_back('{"ldi_r2_07",  mki(2, 2, 8'h07),  8'h07, 8'h0C, 0, 1, 0});
    vecs.push_back('{"jmp_02",     mki(12, 0, 8'h02), 8'h02, 8'h02, 0, 1, 0});
    vecs.push_back('{"jeq_taken",  mk(14, 1, 2, 14),  8'h00, 8'h00, 0, 1, 0});
    vecs.push_back('{"jne_not",    mk(13, 1, 2, 14),  8'h01, 8'h01, 0, 1, 0});
    vecs.push_back('{"ldi_r2_08",  mki(2, 2, 8'h08),  8'h08, 8'h02, 0, 1, 0});
    vecs.push_back('{"jne_taken",  mk(13, 1, 2, 3),   8'h05, 8'h05, 0, 1, 0});
    vecs.push_back('{"and_zero",   mk(5, 1, 2, 7),    8'h00, 8'h06, 1, 0, 0});
    vecs.push_back('{"or",         mk(6, 1, 2, 8),    8'h0F, 8'h07, 0, 0, 0});
    vecs.push_back('{"xor",        mk(10, 1, 2, 9),   8'h0F, 8'h08, 0, 0, 0});
    vecs.push_back('{"cmp",        mk(11, 1, 2, 0),   8'hFF, 8'h09, 0, 1, 0});
    vecs.push_back('{"mov",        mk(7, 10, 2, 0),   8'h08, 8'h0A, 0, 1, 0});
    vecs.push_back('{"ld_r10",     mk(1, 10, 0, 0),   8'h08, 8'h0B, 0, 1, 0});
    vecs.push_back('{"jmp_fe",     mki(12, 0, 8'hFE), 8'hFE, 8'hFE, 0, 1, 0});
    vecs.push_back('{"nop_ff",     mk(0, 0, 0, 0),    8'h00, 8'hFF, 0, 1, 0});
    vecs.push_back('{"nop_wrap",   mk(0, 0, 0, 0),    8'h00, 8'h00, 0, 1, 0});
    vecs.push_back('{"ldi_r11",    mki(2, 11, 8'h55), 8'h55, 8'h01, 0, 1, 0});
    vecs.push_back('{"ldi_r1_10",  mki(2, 1, 8'h10),  8'h10, 8'h02, 0, 1, 0});
    vecs.push_back('{"ldi_r2_10",  mki(2, 2, 8'h10),  8'h10, 8'h03, 0, 1, 0});
`ifdef OAK_MUL_EN
    vecs.push_back('{"mul",        mk(15, 1, 2, 11),  8'h00, 8'h04, 1, 1, 0});
    vecs.push_back('{"ld_r11",     mk(1, 11, 0, 0),   8'h00, 8'h05, 1, 1, 0});
`else
    vecs.push_back('{"op_f_ill",   mk(15, 1, 2, 11),  8'h00, 8'h04, 0, 1, 1});
    vecs.push_back('{"ld_r11",     mk(1, 11, 0, 0),   8'h55, 8'h05, 0, 1, 0});
`endif

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].f);
      checkOutput({vecs[i].name, "_dout"}, 32'(dout), 32'(vecs[i].dout));
      checkOutput({vecs[i].name, "_valid"}, 32'(dout_valid), 1);
      checkOutput({vecs[i].name, "_pc"}, 32'(pc), 32'(vecs[i].pc));
      checkOutput({vecs[i].name, "_z"}, 32'(flag_z), 32'(vecs[i].z));
      checkOutput({vecs[i].name, "_c"}, 32'(flag_c), 32'(vecs[i].c));
      checkOutput({vecs[i].name, "_illegal"}, 32'(illegal), 32'(vecs[i].ill));
    end

    // frame_valid held high; the frame changes during EXEC and must be ignored.
    frame = mki(2, 12, 8'h21); frame_valid = 1'b1;
    @(posedge sysclk); #1;
    modelExec(mki(2, 12, 8'h21));
    checkOutput("held_ready0", 32'(frame_ready), 0);
    frame = mki(2, 12, 8'h99);
    @(posedge sysclk); #1;
    checkModel("held_first");
    checkOutput("held_ready1", 32'(frame_ready), 1);
    frame = mki(2, 13, 8'h42);
    @(posedge sysclk); #1;
    modelExec(mki(2, 13, 8'h42));
    checkOutput("held_ready2", 32'(frame_ready), 0);
    checkOutput("held_valid_gap", 32'(dout_valid), 0);
    @(posedge sysclk); #1;
    frame_valid = 1'b0;
    checkModel("held_second");
    applyStimulus(mk(1, 12, 0, 0));
    checkModel("held_ignored");

    // Reset during EXEC of a RAM store must suppress the write and the result pulse.
    applyStimulus(mki(2, 3, 8'h3C));
    applyStimulus(mki(9, 3, 8'h05));
    checkModel("abort_setup");
    applyStimulus(mki(2, 3, 8'h77));
    frame = mki(9, 3, 8'h05); frame_valid = 1'b1;
    @(posedge sysclk); #1;
    frame_valid = 1'b0; reset = 1'b1;
    @(posedge sysclk); #1;
    checkOutput("abort_valid", 32'(dout_valid), 0);
    checkOutput("abort_ready", 32'(frame_ready), 1);
    checkOutput("abort_pc", 32'(pc), 0);
    reset = 1'b0;
    modelReset();
    applyStimulus(mki(8, 1, 8'h05));
    checkModel("abort_ram_kept");
    applyStimulus(mk(1, 3, 0, 0));
    checkModel("abort_reg_cleared");

    // Random phase: seed the whole RAM, then run random frames against the model.
    for (int i = 0; i < RAM_DEPTH; i++) begin
      applyStimulus(mki(2, 0, int'($urandom_range(0, 255))));
      applyStimulus(mki(9, 0, i));
      checkModel("ram_init");
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(17'($urandom));
      checkModel("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
